// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional feature macro used by the register file: REGFILE_BYPASS_EN
// (write-to-read forwarding within one cycle).
package regfile_pkg;

    // Default data width, used by the word typedef
    localparam int RF_XLEN = 32;

    // 1: reset loads each register with its own index; 0: reset loads zero
    localparam int RF_RESET_INIT_IDX = 1;

    typedef logic [RF_XLEN-1:0] rf_word_t;

    // Address width needed to index n registers
    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for the multi-port register file.
// For every register it produces a write strobe and the index of the winning
// write port. When ports collide on one address, the highest-index port wins.
// Register 0 never gets a strobe when ZERO_REG is set. An address past the
// end of the file never matches a register, so such writes fall away.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(NREGS),
    localparam int SW      = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    output logic [NREGS-1:0]         we,
    output logic [NREGS-1:0][SW-1:0] sel
);

    // Scan ports in ascending order so a later (higher) port overrides earlier ones
    always_comb begin
        we  = '0;
        sel = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == AW'(r)) && ((ZERO_REG == 0) || (r != 0))) begin
                    we[r]  = 1'b1;
                    sel[r] = SW'(k);
                end else begin
                    we[r]  = we[r];
                    sel[r] = sel[r];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a busy scoreboard.
// NRD registered read ports, NWR prioritised write ports, one reserve port
// that marks registers busy, and a combinational debug probe.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// to a read of the same address. The forwarded read also sees the busy bit
// after that cycle's write and reserve. Without the macro, a read returns
// the value and the busy bit from before the edge.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(NREGS),
    localparam int SW      = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NRD-1:0]             rd_en,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][XLEN-1:0]   rd_data,
    output logic [NRD-1:0]             rd_valid,
    output logic [NRD-1:0]             rd_hazard,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR-1:0][AW-1:0]     wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    output logic [NREGS-1:0]           busy,
    input  logic [AW-1:0]              dbg_addr,
    output logic [XLEN-1:0]            dbg_data
);

    logic [XLEN-1:0]         regs_r [NREGS];
    logic [NREGS-1:0]        busy_nxt_s;
    logic [NREGS-1:0]        we_s;
    logic [NREGS-1:0][SW-1:0] sel_s;
    logic [NRD-1:0][XLEN-1:0] rd_word_s;
    logic [NRD-1:0]          rd_haz_s;

    // True when the address names a register that exists
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(NREGS));
    endfunction

    regfile_wr_arb #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .we      (we_s),
        .sel     (sel_s)
    );

    // Register array: reset loads index values, then takes the winning port's data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (RF_RESET_INIT_IDX != 0) ? XLEN'(i) : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_s[i]) begin
                    regs_r[i] <= wr_data[sel_s[i]];
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Scoreboard next state: a reserve beats a clearing write to the same register
    always_comb begin
        busy_nxt_s = busy_r_view();
        for (int r = 0; r < NREGS; r++) begin
            if (rsv_en && (rsv_addr == AW'(r)) && ((ZERO_REG == 0) || (r != 0))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (we_s[r]) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy[r];
            end
        end
    end

    // Present scoreboard state, read back by the next-state logic
    function automatic logic [NREGS-1:0] busy_r_view();
        return busy;
    endfunction

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt_s;
        end
    end

    // Read-data select per port, with optional same-cycle write forwarding
    always_comb begin
        rd_word_s = '0;
        rd_haz_s  = '0;
        for (int p = 0; p < NRD; p++) begin
            if (in_range(rd_addr[p])) begin
`ifdef REGFILE_BYPASS_EN
                if (we_s[rd_addr[p]]) begin
                    rd_word_s[p] = wr_data[sel_s[rd_addr[p]]];
                end else begin
                    rd_word_s[p] = regs_r[rd_addr[p]];
                end
                rd_haz_s[p] = busy_nxt_s[rd_addr[p]];
`else
                rd_word_s[p] = regs_r[rd_addr[p]];
                rd_haz_s[p]  = busy[rd_addr[p]];
`endif
            end else begin
                rd_word_s[p] = '0;
                rd_haz_s[p]  = 1'b0;
            end
        end
    end

    // Read output registers: data holds while a port is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data   <= '0;
            rd_valid  <= '0;
            rd_hazard <= '0;
        end else begin
            rd_valid  <= rd_en;
            rd_hazard <= rd_en & rd_haz_s;
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= rd_word_s[p];
                end else begin
                    rd_data[p] <= rd_data[p];
                end
            end
        end
    end

    // Debug probe straight from the array, no forwarding
    always_comb begin
        if (in_range(dbg_addr)) begin
            dbg_data = regs_r[dbg_addr];
        end else begin
            dbg_data = '0;
        end
    end

endmodule
